// File: rtl/render_scheduler.sv
// render_scheduler
//   Per-frame sequencer for the object controllers (bird, pipes, score).
//   Each frame tick runs every object through erase -> update -> draw,
//   serialising access to the shared framebuffer plotter so that only one
//   object plots at a time.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for a tick (live or pending) while enabled
//   ERASE_REQ  | erase_start[idx] pulse, wait counter cleared
//   ERASE_WAIT | waiting for done[idx] or timeout
//   UPDATE     | update_en all ones for one cycle
//   DRAW_REQ   | draw_start[idx] pulse, wait counter cleared
//   DRAW_WAIT  | waiting for done[idx] or timeout
//   DONE       | frame_done pulse, frame_count advances
//
// Ports
//   clk, resetn   clock, asynchronous active-low reset
//   frame_tick    one-cycle pulse per video frame
//   enable        gates the start of new frames only
//   clear_err     synchronous clear of overrun / timeout_err
//   done          per-object completion pulse for the current job
//   erase_start   one-hot erase start pulse
//   update_en     all-ones update strobe
//   draw_start    one-hot draw start pulse
//   plot_sel      index of the object owning the plotter
//   frame_busy    high from first erase_start through DONE
//   frame_done    one-cycle pulse at frame completion
//   frame_count   completed frames, wraps at 256
//   overrun       sticky: a tick was dropped
//   timeout_err   sticky: a wait reached TIMEOUT
module render_scheduler #(
    parameter int N_OBJ   = 3,
    parameter int TIMEOUT = 1023,
    localparam int IDX_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             clear_err,
    input  logic [N_OBJ-1:0] done,
    output logic [N_OBJ-1:0] erase_start,
    output logic [N_OBJ-1:0] update_en,
    output logic [N_OBJ-1:0] draw_start,
    output logic [IDX_W-1:0] plot_sel,
    output logic             frame_busy,
    output logic             frame_done,
    output logic [7:0]       frame_count,
    output logic             overrun,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ERASE_REQ  = 3'd1,
        ERASE_WAIT = 3'd2,
        UPDATE     = 3'd3,
        DRAW_REQ   = 3'd4,
        DRAW_WAIT  = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OBJ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             pending;
    logic             timeout_evt;
    logic             wait_over;
    logic             frame_start;
    logic             tick_deferred;

    // A wait ends on the served object's done, or when the counter has run
    // out; the latter is treated as a done that never came.
    assign wait_over     = done[idx] || (wait_cnt == CNT_LAST);
    assign frame_start   = (state == IDLE) && enable && (pending || frame_tick);
    assign tick_deferred = frame_tick && ((state != IDLE) || !enable);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        wait_cnt_nxt = wait_cnt;
        timeout_evt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    idx_nxt   = '0;
                    state_nxt = ERASE_REQ;
                end
            end
            ERASE_REQ: begin
                wait_cnt_nxt = '0;
                state_nxt    = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                wait_cnt_nxt = wait_cnt + 1'b1;
                if (wait_over) begin
                    timeout_evt = !done[idx];
                    if (idx == IDX_LAST) begin
                        state_nxt = UPDATE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ERASE_REQ;
                    end
                end
            end
            UPDATE: begin
                idx_nxt   = '0;
                state_nxt = DRAW_REQ;
            end
            DRAW_REQ: begin
                wait_cnt_nxt = '0;
                state_nxt    = DRAW_WAIT;
            end
            DRAW_WAIT: begin
                wait_cnt_nxt = wait_cnt + 1'b1;
                if (wait_over) begin
                    timeout_evt = !done[idx];
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = DRAW_REQ;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tick bookkeeping: one tick may wait while a frame runs or while the
    // game is paused; a further one is dropped and flagged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending <= 1'b0;
        end else if (frame_start) begin
            pending <= 1'b0;
        end else if (tick_deferred) begin
            pending <= 1'b1;
        end
    end

    // Error flags: a set in the same cycle as clear_err takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tick_deferred && pending) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count <= 8'd0;
        end else if (state == DONE) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    always_comb begin
        erase_start = '0;
        update_en   = '0;
        draw_start  = '0;
        plot_sel    = '0;
        frame_busy  = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
            end
            ERASE_REQ: begin
                erase_start = N_OBJ'(1) << idx;
                plot_sel    = idx;
                frame_busy  = 1'b1;
            end
            ERASE_WAIT: begin
                plot_sel   = idx;
                frame_busy = 1'b1;
            end
            UPDATE: begin
                update_en  = '1;
                frame_busy = 1'b1;
            end
            DRAW_REQ: begin
                draw_start = N_OBJ'(1) << idx;
                plot_sel   = idx;
                frame_busy = 1'b1;
            end
            DRAW_WAIT: begin
                plot_sel   = idx;
                frame_busy = 1'b1;
            end
            DONE: begin
                frame_done = 1'b1;
                frame_busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler
//   Scoreboard bench for render_scheduler (N_OBJ=3, TIMEOUT=8). Stimulus
//   pushes the expected output events (cycle, pulse pattern, plot_sel)
//   before each tick; a monitor pops and compares on every cycle where the
//   scheduler presents a pulse. Automatic responders answer each start
//   pulse with a programmable latency (0 = never answer).
module tb_render_scheduler;

    localparam int N  = 3;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       clear_err = 1'b0;
    logic [2:0] resp_done = '0;
    logic [2:0] extra_done = '0;
    logic [2:0] done;
    logic [2:0] erase_start, update_en, draw_start;
    logic [1:0] plot_sel;
    logic       frame_busy, frame_done, overrun, timeout_err;
    logic [7:0] frame_count;

    assign done = resp_done | extra_done;

    render_scheduler #(.N_OBJ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .clear_err   (clear_err),
        .done        (done),
        .erase_start (erase_start),
        .update_en   (update_en),
        .draw_start  (draw_start),
        .plot_sel    (plot_sel),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       c;
        logic [2:0] es;
        logic [2:0] ue;
        logic [2:0] ds;
        logic       fd;
        logic [1:0] ps;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad = 0;

    int lat_e[3];
    int lat_d[3];
    int rcnt[3];

    // Responders
    always @(negedge clk) begin
        resp_done = '0;
        for (int i = 0; i < 3; i++) begin
            if (!resetn) begin
                rcnt[i] = 0;
            end else begin
                if (rcnt[i] > 0) begin
                    rcnt[i] = rcnt[i] - 1;
                    if (rcnt[i] == 0) resp_done[i] = 1'b1;
                end
                if (erase_start[i] && lat_e[i] > 0) rcnt[i] = lat_e[i];
                if (draw_start[i] && lat_d[i] > 0) rcnt[i] = lat_d[i];
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (resetn && ((erase_start | update_en | draw_start) != 3'b000 || frame_done)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d es=%b ue=%b ds=%b fd=%b", cyc, erase_start, update_en, draw_start, frame_done);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.c || erase_start !== mon_e.es || update_en !== mon_e.ue ||
                    draw_start !== mon_e.ds || frame_done !== mon_e.fd ||
                    plot_sel !== mon_e.ps || frame_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL event got cyc=%0d es=%b ue=%b ds=%b fd=%b ps=%0d busy=%b expected cyc=%0d es=%b ue=%b ds=%b fd=%b ps=%0d busy=1",
                             cyc, erase_start, update_en, draw_start, frame_done, plot_sel, frame_busy,
                             mon_e.c, mon_e.es, mon_e.ue, mon_e.ds, mon_e.fd, mon_e.ps);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] es, input logic [2:0] ue,
                           input logic [2:0] ds, input logic fd, input logic [1:0] ps);
        ev_t e;
        e.c = c; e.es = es; e.ue = ue; e.ds = ds; e.fd = fd; e.ps = ps;
        exp_q.push_back(e);
    endtask

    // Frame started in cycle t with every responder at latency l.
    task automatic push_frame(input int t, input int l);
        int p;
        p = l + 1;
        for (int i = 0; i < 3; i++) push_ev(t + 1 + i * p, 3'(1 << i), 3'b000, 3'b000, 1'b0, 2'(i));
        push_ev(t + 1 + 3 * p, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) push_ev(t + 2 + 3 * p + i * p, 3'b000, 3'b000, 3'(1 << i), 1'b0, 2'(i));
        push_ev(t + 2 + 6 * p, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
    endtask

    task automatic set_lat(input int l);
        for (int i = 0; i < 3; i++) begin
            lat_e[i] = l;
            lat_d[i] = l;
        end
    endtask

    // Call at a falling edge: pulses frame_tick for the current cycle.
    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic go_to(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain left=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int t;

    initial begin
        set_lat(2);
        #2;
        chk("rst_erase_start", 32'(erase_start), 0);
        chk("rst_frame_busy", 32'(frame_busy), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_errors", 32'({overrun, timeout_err}), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // 1: basic frame, responders answer 2 cycles after start
        @(negedge clk);
        t = cyc;
        push_ev(t + 1,  3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        push_ev(t + 4,  3'b010, 3'b000, 3'b000, 1'b0, 2'd1);
        push_ev(t + 7,  3'b100, 3'b000, 3'b000, 1'b0, 2'd2);
        push_ev(t + 10, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0);
        push_ev(t + 11, 3'b000, 3'b000, 3'b001, 1'b0, 2'd0);
        push_ev(t + 14, 3'b000, 3'b000, 3'b010, 1'b0, 2'd1);
        push_ev(t + 17, 3'b000, 3'b000, 3'b100, 1'b0, 2'd2);
        push_ev(t + 20, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        pulse_tick();
        drain("basic", 60);
        chk("basic_frame_count", 32'(frame_count), 1);
        chk("basic_busy_idle", 32'(frame_busy), 0);

        // 2: pending tick and overrun, back-to-back frames
        @(negedge clk);
        t = cyc;
        push_frame(t, 2);
        push_frame(t + 21, 2);
        pulse_tick();
        go_to(t + 3);
        pulse_tick();
        go_to(t + 6);
        chk("overrun_before_drop", 32'(overrun), 0);
        pulse_tick();
        drain("backtoback", 80);
        chk("b2b_frame_count", 32'(frame_count), 3);
        chk("overrun_set", 32'(overrun), 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("overrun_cleared", 32'(overrun), 0);

        // 3: object 1 never answers its erase
        chk("timeout_err_clean", 32'(timeout_err), 0);
        lat_e[1] = 0;
        @(negedge clk);
        t = cyc;
        push_ev(t + 1,  3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        push_ev(t + 4,  3'b010, 3'b000, 3'b000, 1'b0, 2'd1);
        push_ev(t + 13, 3'b100, 3'b000, 3'b000, 1'b0, 2'd2);
        push_ev(t + 16, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0);
        push_ev(t + 17, 3'b000, 3'b000, 3'b001, 1'b0, 2'd0);
        push_ev(t + 20, 3'b000, 3'b000, 3'b010, 1'b0, 2'd1);
        push_ev(t + 23, 3'b000, 3'b000, 3'b100, 1'b0, 2'd2);
        push_ev(t + 26, 3'b000, 3'b000, 3'b000, 1'b1, 2'd0);
        pulse_tick();
        go_to(t + 12);
        chk("timeout_not_yet", 32'(timeout_err), 0);
        chk("timeout_plot_sel", 32'(plot_sel), 1);
        drain("timeout", 80);
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_frame_count", 32'(frame_count), 4);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("timeout_err_cleared", 32'(timeout_err), 0);
        lat_e[1] = 2;

        // 4: spurious done bits are ignored
        @(negedge clk);
        t = cyc;
        push_frame(t, 2);
        pulse_tick();
        extra_done = 3'b001;
        @(negedge clk);
        extra_done = 3'b100;
        @(negedge clk);
        extra_done = 3'b000;
        drain("spurious", 60);
        chk("spurious_frame_count", 32'(frame_count), 5);
        chk("spurious_no_timeout", 32'(timeout_err), 0);

        // 5: enable drops during DRAW_WAIT of object 1
        @(negedge clk);
        t = cyc;
        push_frame(t, 2);
        pulse_tick();
        go_to(t + 15);
        enable = 1'b0;
        drain("enable_drop", 60);
        chk("en_drop_frame_count", 32'(frame_count), 6);
        go_to(t + 26);
        pulse_tick();
        repeat (5) @(negedge clk);
        chk("paused_no_start", 32'(frame_busy), 0);
        chk("paused_no_overrun", 32'(overrun), 0);
        t = cyc;
        push_frame(t, 2);
        enable = 1'b1;
        drain("resume", 60);
        chk("resume_frame_count", 32'(frame_count), 7);

        // 6: asynchronous reset during ERASE_WAIT
        @(negedge clk);
        t = cyc;
        push_ev(t + 1, 3'b001, 3'b000, 3'b000, 1'b0, 2'd0);
        pulse_tick();
        @(negedge clk);
        chk("pre_reset_busy", 32'(frame_busy), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_outputs", 32'({erase_start, update_en, draw_start, plot_sel, frame_busy, frame_done}), 0);
        chk("areset_frame_count", 32'(frame_count), 0);
        chk("areset_errors", 32'({overrun, timeout_err}), 0);
        chk("areset_queue", 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", 32'(frame_busy), 0);
        @(negedge clk);
        t = cyc;
        push_frame(t, 2);
        pulse_tick();
        drain("after_reset", 60);
        chk("after_reset_count", 32'(frame_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
